// File: rtl/mem_if_pkg.sv
// Shared types and constants for data-memory initiators.
// FSM state encoding and address strides used by the scan engines.
package mem_if_pkg;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WR_MIN,
      WR_IDX,
      DONE
   } state_t;

   localparam int WORD_BYTES        = 4;
   localparam int RESULT_IDX_OFFSET = 4;

endpackage

// File: rtl/min_cmp.sv
// Signed running-minimum selector.
// The first flag forces a load; otherwise only a strictly smaller value wins.
module min_cmp #(
   parameter int DW = 32
) (
   input  logic          first,
   input  logic [DW-1:0] cur_min,
   input  logic [DW-1:0] cur_idx,
   input  logic [DW-1:0] val,
   input  logic [DW-1:0] idx,
   output logic [DW-1:0] nxt_min,
   output logic [DW-1:0] nxt_idx
);

   logic take;

   // Ties keep the earlier index, so equality must not take.
   assign take = first | ($signed(val) < $signed(cur_min));

   always_comb begin
      nxt_min = cur_min;
      nxt_idx = cur_idx;
      if (take) begin
         nxt_min = val;
         nxt_idx = idx;
      end
   end

endmodule

// File: rtl/min_scan_master.sv
// Min-search offload: scans COUNT signed words, then writes min and index.
// Drives the data-memory load/store port in place of the CPU.
module min_scan_master
   import mem_if_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] base_adr,
   input  logic [CW-1:0] count,
   input  logic [AW-1:0] res_adr,
   output logic [AW-1:0] adr,
   output logic [DW-1:0] d_in,
   output logic          mrd,
   output logic          mwr,
   input  logic [DW-1:0] d_out,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] min,
   output logic [DW-1:0] min_idx
);

   state_t        state;
   logic [CW-1:0] i;
   logic [CW-1:0] cnt;
   logic [AW-1:0] res;
   logic [DW-1:0] nxt_min;
   logic [DW-1:0] nxt_idx;
   logic          last;
   logic          first;

   assign last  = (i == cnt - CW'(1));
   assign first = (i == '0);

   min_cmp #(.DW(DW)) u_cmp (
      .first   (first),
      .cur_min (min),
      .cur_idx (min_idx),
      .val     (d_out),
      .idx     (DW'(i)),
      .nxt_min (nxt_min),
      .nxt_idx (nxt_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         adr     <= '0;
         d_in    <= '0;
         mrd     <= 1'b0;
         mwr     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         min     <= '0;
         min_idx <= '0;
         i       <= '0;
         cnt     <= '0;
         res     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               mrd  <= 1'b0;
               mwr  <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  cnt  <= count;
                  res  <= res_adr;
                  i    <= '0;
                  busy <= 1'b1;
                  if (count != '0) begin
                     state <= READ;
                     adr   <= base_adr;
                     mrd   <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            READ: begin
               min     <= nxt_min;
               min_idx <= nxt_idx;
               if (last) begin
                  state <= WR_MIN;
                  mrd   <= 1'b0;
                  mwr   <= 1'b1;
                  adr   <= res;
                  d_in  <= nxt_min;
               end else begin
                  i   <= i + CW'(1);
                  adr <= adr + AW'(WORD_BYTES);
               end
            end
            WR_MIN: begin
               state <= WR_IDX;
               adr   <= res + AW'(RESULT_IDX_OFFSET);
               d_in  <= min_idx;
            end
            WR_IDX: begin
               state <= DONE;
               mwr   <= 1'b0;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
